// File: rtl/regfile_write_port.sv
// Write side of the register file: buffers write requests in a small FIFO and commits one per
// falling clock edge into a flat register bank, flagging buffered writes that hit rd_addr.
module regfile_write_port #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic                     pending_hit,
    output logic [NREGS*WIDTH-1:0]   regs_flat,
    output logic                     wr_done,
    output logic [AW-1:0]            done_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0]    fifo_addr_q [DEPTH];
    logic [AW-1:0]    fifo_addr_d [DEPTH];
    logic [WIDTH-1:0] fifo_data_q [DEPTH];
    logic [WIDTH-1:0] fifo_data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             wr_done_q, wr_done_d;
    logic [AW-1:0]    done_addr_q, done_addr_d;
    logic [NREGS-1:0] wr_en;
    logic             push, pop;

    assign wr_ready  = (count_q != CW'(DEPTH));
    assign wr_done   = wr_done_q;
    assign done_addr = done_addr_q;
    assign count     = count_q;

    always_comb begin
        push        = wr_valid && wr_ready;
        pop         = (count_q != '0);
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        valid_d     = valid_q;
        head_d      = head_q;
        tail_d      = tail_q;
        wr_en       = '0;
        wr_done_d   = 1'b0;
        done_addr_d = done_addr_q;

        if (push) begin
            fifo_addr_d[tail_q] = wr_addr;
            fifo_data_d[tail_q] = wr_data;
            valid_d[tail_q]     = 1'b1;
            tail_d              = tail_q + PW'(1);
        end
        // A pop never aliases the push slot: head == tail with count != 0 only when full.
        if (pop) begin
            wr_en           = NREGS'(1) << fifo_addr_q[head_q];
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
            wr_done_d       = 1'b1;
            done_addr_d     = fifo_addr_q[head_q];
        end
        if (ZERO_REG != 0) begin
            wr_en[0] = 1'b0;
        end

        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = wr_en[i] ? fifo_data_q[head_q] : regs_q[i];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pending_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (fifo_addr_q[i] == rd_addr)) begin
                pending_hit = 1'b1;
            end
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            pending_hit = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            wr_done_q   <= 1'b0;
            done_addr_q <= '0;
        end else begin
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
            regs_q      <= regs_d;
            valid_q     <= valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            wr_done_q   <= wr_done_d;
            done_addr_q <= done_addr_d;
        end
    end

endmodule
